// File: rtl/gppcu_instr_dispatcher_pkg.sv
// Shared definitions for the GPPCU instruction dispatcher: default widths and
// the dispatch state encoding that host glue uses to decode busy/done.
package gppcu_instr_dispatcher_pkg;

  localparam int GPPCU_DBW        = 32;
  localparam int GPPCU_DEPTH_LOG2 = 4;
  localparam int GPPCU_CNTW       = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } disp_state_e;

endpackage

// File: rtl/gppcu_instr_dispatcher_if.sv
// Instruction valid/ready bus between the dispatcher (master) and the GPPCU core (slave).
interface gppcu_instr_dispatcher_if
  import gppcu_instr_dispatcher_pkg::*;
#(
  parameter int DBW = GPPCU_DBW
);

  logic [DBW-1:0] oINSTR;
  logic           oINSTR_VALID;
  logic           iINSTR_READY;

  modport master (
    output oINSTR,
    output oINSTR_VALID,
    input  iINSTR_READY
  );

  modport slave (
    input  oINSTR,
    input  oINSTR_VALID,
    output iINSTR_READY
  );

endinterface

// File: rtl/gppcu_sync_fifo.sv
// Single-clock register FIFO with combinational head read and synchronous clear.
module gppcu_sync_fifo
  import gppcu_instr_dispatcher_pkg::*;
#(
  parameter int DBW        = GPPCU_DBW,
  parameter int DEPTH_LOG2 = GPPCU_DEPTH_LOG2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DBW-1:0]        i_data,
  input  logic                  i_pop,
  input  logic                  i_clear,
  output logic [DBW-1:0]        o_head,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DBW-1:0]        r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  w_push;
  logic                  w_pop;

  // level can only reach DEPTH, so its MSB alone means full
  assign o_full  = r_level[DEPTH_LOG2];
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full  && !i_clear;
  assign w_pop  = i_pop  && !o_empty && !i_clear;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/gppcu_instr_dispatcher.sv
// Host-side instruction source: buffers host words and streams them to the GPPCU core.
// Optional stall counter enabled by defining GPPCU_DISPATCH_PERF_EN.
module gppcu_instr_dispatcher
  import gppcu_instr_dispatcher_pkg::*;
#(
  parameter int DBW        = GPPCU_DBW,
  parameter int DEPTH_LOG2 = GPPCU_DEPTH_LOG2,
  parameter int CNTW       = GPPCU_CNTW
) (
  input  logic                      iACLK,
  input  logic                      inRST,
  input  logic [DBW-1:0]            iHOST_WDATA,
  input  logic                      iHOST_WR,
  output logic                      oHOST_FULL,
  output logic [DEPTH_LOG2:0]       oHOST_LEVEL,
  output logic                      oOVERFLOW,
  input  logic                      iSTART,
  input  logic                      iFLUSH,
  output logic                      oBUSY,
  output logic                      oDONE,
  gppcu_instr_dispatcher_if.master  instr_if,
  output logic [CNTW-1:0]           oISSUED_CNT,
  output logic [CNTW-1:0]           oSTALL_CNT
);

  localparam logic [DEPTH_LOG2:0] LVL_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  disp_state_e         r_state;
  logic [CNTW-1:0]     r_issued;
  logic                r_overflow;

  logic [DBW-1:0]      w_head;
  logic [DEPTH_LOG2:0] w_level;
  logic                w_full;
  logic                w_empty;
  logic                w_valid;
  logic                w_hs;
  logic                w_push_ok;
  logic                w_start_ok;

  gppcu_sync_fifo #(
    .DBW        (DBW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .i_clk   (iACLK),
    .i_rst_n (inRST),
    .i_push  (iHOST_WR),
    .i_data  (iHOST_WDATA),
    .i_pop   (w_hs),
    .i_clear (iFLUSH),
    .o_head  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // flush gates valid so the core never sees a transfer in the clearing cycle
  assign w_valid    = (r_state == ST_RUN) && !w_empty && !iFLUSH;
  assign w_hs       = w_valid && instr_if.iINSTR_READY;
  assign w_push_ok  = iHOST_WR && !w_full;
  assign w_start_ok = (r_state == ST_IDLE) && iSTART && !iFLUSH;

  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      r_state    <= ST_IDLE;
      r_issued   <= '0;
      r_overflow <= 1'b0;
    end else if (iFLUSH) begin
      r_state    <= ST_IDLE;
      r_overflow <= 1'b0;
    end else begin
      if (iHOST_WR && w_full) r_overflow <= 1'b1;
      if (w_hs)               r_issued   <= r_issued + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_issued <= '0;
            r_state  <= w_empty ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          // a same-cycle host write keeps the stream alive past the last pop
          if (w_empty || (w_hs && (w_level == LVL_ONE) && !w_push_ok)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef GPPCU_DISPATCH_PERF_EN
  logic [CNTW-1:0] r_stall;

  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      r_stall <= '0;
    end else if (w_start_ok) begin
      r_stall <= '0;
    end else if (w_valid && !instr_if.iINSTR_READY && (r_stall != '1)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign oSTALL_CNT = r_stall;
`else
  assign oSTALL_CNT = '0;
`endif

  assign oHOST_FULL            = w_full;
  assign oHOST_LEVEL           = w_level;
  assign oOVERFLOW             = r_overflow;
  assign oBUSY                 = (r_state == ST_RUN);
  assign oDONE                 = (r_state == ST_DONE);
  assign oISSUED_CNT           = r_issued;
  assign instr_if.oINSTR       = w_head;
  assign instr_if.oINSTR_VALID = w_valid;

endmodule

// File: tb/tb_gppcu_instr_dispatcher.sv
// Scoreboard bench for gppcu_instr_dispatcher: queue-based reference model, directed and random stimulus.
module tb_gppcu_instr_dispatcher;

  localparam int DBW   = 32;
  localparam int DL2   = 4;
  localparam int CNTW  = 16;
  localparam int DEPTH = 16;
`ifdef GPPCU_DISPATCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [DBW-1:0]  wdata;
  logic            wr;
  logic            start;
  logic            flush;
  logic            full;
  logic [DL2:0]    level;
  logic            ovf;
  logic            busy;
  logic            done;
  logic [CNTW-1:0] issued;
  logic [CNTW-1:0] stall;

  gppcu_instr_dispatcher_if #(.DBW(DBW)) bus ();

  gppcu_instr_dispatcher #(
    .DBW        (DBW),
    .DEPTH_LOG2 (DL2),
    .CNTW       (CNTW)
  ) dut (
    .iACLK       (clk),
    .inRST       (rst_n),
    .iHOST_WDATA (wdata),
    .iHOST_WR    (wr),
    .oHOST_FULL  (full),
    .oHOST_LEVEL (level),
    .oOVERFLOW   (ovf),
    .iSTART      (start),
    .iFLUSH      (flush),
    .oBUSY       (busy),
    .oDONE       (done),
    .instr_if    (bus),
    .oISSUED_CNT (issued),
    .oSTALL_CNT  (stall)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: FIFO contents as a queue plus the dispatch phase
  logic [31:0] m_q[$];
  logic [31:0] exp_q[$];
  int          m_phase;
  bit          m_ovf;
  logic [15:0] m_issued;
  logic [15:0] m_stall;

  // expected outputs for the current cycle
  bit          e_valid, e_done, e_busy, e_ovf, e_full;
  int          e_level;
  logic [15:0] e_issued, e_stall;
  bit          chk_en;

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_phase  = PH_IDLE;
    m_ovf    = 1'b0;
    m_issued = '0;
    m_stall  = '0;
    e_valid  = 1'b0;
    e_done   = 1'b0;
    e_busy   = 1'b0;
    e_ovf    = 1'b0;
    e_full   = 1'b0;
    e_level  = 0;
    e_issued = '0;
    e_stall  = '0;
  endtask

  task automatic cyc(input bit w, input logic [31:0] d, input bit st, input bit fl, input bit rdy);
    int sz;
    bit v, hs, push;
    @(posedge clk);
    #1;
    wr = w; wdata = d; start = st; flush = fl; bus.iINSTR_READY = rdy;
    sz = m_q.size();
    v  = (m_phase == PH_RUN) && (sz > 0) && !fl;
    hs = v && rdy;
    e_valid  = v;
    e_done   = (m_phase == PH_DONE);
    e_busy   = (m_phase == PH_RUN);
    e_ovf    = m_ovf;
    e_full   = (sz == DEPTH);
    e_level  = sz;
    e_issued = m_issued;
    e_stall  = m_stall;
    if (hs) exp_q.push_back(m_q[0]);
    if (fl) begin
      m_q.delete();
      m_phase = PH_IDLE;
      m_ovf   = 1'b0;
    end else begin
      push = w && (sz < DEPTH);
      if (w && sz == DEPTH) m_ovf = 1'b1;
      if (hs) begin
        void'(m_q.pop_front());
        m_issued++;
      end
      if (push) m_q.push_back(d);
      if (PERF && v && !rdy && m_stall != 16'hffff) m_stall++;
      case (m_phase)
        PH_IDLE: if (st) begin
          m_issued = '0;
          m_stall  = '0;
          m_phase  = (sz > 0) ? PH_RUN : PH_DONE;
        end
        PH_RUN: if (sz == 0 || (hs && sz == 1 && !push)) m_phase = PH_DONE;
        default: m_phase = PH_IDLE;
      endcase
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_level"},  32'(level), 32'd0);
    chk({tag, "_full"},   32'(full), 32'd0);
    chk({tag, "_ovf"},    32'(ovf), 32'd0);
    chk({tag, "_busy"},   32'(busy), 32'd0);
    chk({tag, "_done"},   32'(done), 32'd0);
    chk({tag, "_valid"},  32'(bus.oINSTR_VALID), 32'd0);
    chk({tag, "_instr"},  bus.oINSTR, 32'd0);
    chk({tag, "_issued"}, 32'(issued), 32'd0);
    chk({tag, "_stall"},  32'(stall), 32'd0);
  endtask

  // monitor: per-cycle output check and transfer scoreboard
  bit          p_vld, p_rdy;
  logic [31:0] p_instr;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid",    32'(bus.oINSTR_VALID), 32'(e_valid));
      chk("done",     32'(done), 32'(e_done));
      chk("busy",     32'(busy), 32'(e_busy));
      chk("overflow", 32'(ovf), 32'(e_ovf));
      chk("full",     32'(full), 32'(e_full));
      chk("level",    32'(level), 32'(e_level));
      chk("issued",   32'(issued), 32'(e_issued));
      chk("stall",    32'(stall), 32'(e_stall));
      if (e_level == 0) chk("instr_empty_zero", bus.oINSTR, 32'd0);
      if (p_vld && !p_rdy && !flush) begin
        chk("hold_valid", 32'(bus.oINSTR_VALID), 32'd1);
        chk("hold_instr", bus.oINSTR, p_instr);
      end
      if (bus.oINSTR_VALID && bus.iINSTR_READY) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL xfer_unexpected: got 0x%0h expected no transfer at %0t", bus.oINSTR, $time);
        end else begin
          chk("xfer_data", bus.oINSTR, exp_q.pop_front());
        end
      end
      p_vld   = bus.oINSTR_VALID;
      p_rdy   = bus.iINSTR_READY;
      p_instr = bus.oINSTR;
    end else begin
      p_vld = 1'b0;
    end
  end

  initial begin
    chk_en = 1'b0;
    rst_n  = 1'b0;
    wr = 1'b0; wdata = '0; start = 1'b0; flush = 1'b0;
    bus.iINSTR_READY = 1'b0;
    model_reset();
    #2;
    chk_reset_vals("por");
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // burst of three with READY held high
    cyc(1, 32'h11, 0, 0, 1);
    cyc(1, 32'h22, 0, 0, 1);
    cyc(1, 32'h33, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    repeat (6) cyc(0, 0, 0, 0, 1);
    #1 chk("burst_issued", 32'(issued), 32'd3);

    // backpressure: four stall cycles before acceptance
    cyc(1, 32'hA1, 0, 0, 0);
    cyc(1, 32'hA2, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 1);
    #1;
    chk("bp_stall_cnt", 32'(stall), PERF ? 32'd4 : 32'd0);
    chk("bp_issued", 32'(issued), 32'd2);

    // overflow at the full boundary
    for (int i = 0; i < 17; i++) cyc(1, 32'h100 + 32'(i), 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    #1;
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    cyc(0, 0, 1, 0, 1);
    repeat (20) cyc(0, 0, 0, 0, 1);
    #1 chk("ovf_issued", 32'(issued), 32'd16);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    #1 chk("ovf_cleared", 32'(ovf), 32'd0);

    // write lands in the same cycle as the last pop
    cyc(1, 32'h99, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 32'h55, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    #1;
    chk("simul_level", 32'(level), 32'd1);
    chk("simul_busy", 32'(busy), 32'd1);
    repeat (4) cyc(0, 0, 0, 0, 1);

    // start with an empty FIFO
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    #1;
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_issued", 32'(issued), 32'd0);
    repeat (2) cyc(0, 0, 0, 0, 1);

    // flush during a stall with five words queued
    for (int i = 0; i < 5; i++) cyc(1, 32'h200 + 32'(i), 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    #1 chk("flush_valid_comb", 32'(bus.oINSTR_VALID), 32'd0);
    cyc(0, 0, 0, 0, 1);
    #1;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    repeat (3) cyc(0, 0, 0, 0, 1);

    // asynchronous reset in the middle of a run
    for (int i = 0; i < 4; i++) cyc(1, 32'h300 + 32'(i), 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0);
    @(posedge clk); #3;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    model_reset();
    wr = 1'b0; wdata = '0; start = 1'b0; flush = 1'b0;
    bus.iINSTR_READY = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom,
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 79) == 0),
          ($urandom_range(0, 2) != 0));
    end
    cyc(0, 0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    #1 chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
